// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - ALU issue controller constants, opcode patterns and FSM state type
package alu_issue_pkg;

  // ALUCtrl codes understood by the combinational ALU
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  // LEGv8 opcode field is instruction bits [31:21]
  localparam int OPC_W = 11;

  localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_ADDI = 11'b10010001000;
  localparam logic [OPC_W-1:0] OPC_SUBI = 11'b11010001000;
  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [OPC_W-1:0] OPC_CBZ  = 11'b10110100000;

  // I-format opcodes ignore bit 0, CB-format opcodes ignore bits [2:0]
  localparam logic [OPC_W-1:0] MASK_FULL = 11'b11111111111;
  localparam logic [OPC_W-1:0] MASK_IMM  = 11'b11111111110;
  localparam logic [OPC_W-1:0] MASK_CB   = 11'b11111111000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_t;

  function automatic logic opc_match(input logic [OPC_W-1:0] op,
                                     input logic [OPC_W-1:0] pat,
                                     input logic [OPC_W-1:0] mask);
    return (op & mask) == (pat & mask);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational LEGv8 opcode to ALUCtrl decoder with legal flag
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [3:0]       alu_ctrl,
  output logic             legal
);

  // Priority chain over disjoint patterns; anything unmatched is illegal
  always_comb begin
    alu_ctrl = ALU_AND;
    legal    = 1'b1;
    if (opc_match(opcode, OPC_ADD, MASK_FULL))       alu_ctrl = ALU_ADD;
    else if (opc_match(opcode, OPC_SUB, MASK_FULL))  alu_ctrl = ALU_SUB;
    else if (opc_match(opcode, OPC_AND, MASK_FULL))  alu_ctrl = ALU_AND;
    else if (opc_match(opcode, OPC_ORR, MASK_FULL))  alu_ctrl = ALU_OR;
    else if (opc_match(opcode, OPC_ADDI, MASK_IMM))  alu_ctrl = ALU_ADD;
    else if (opc_match(opcode, OPC_SUBI, MASK_IMM))  alu_ctrl = ALU_SUB;
    else if (opc_match(opcode, OPC_LDUR, MASK_FULL)) alu_ctrl = ALU_ADD;
    else if (opc_match(opcode, OPC_STUR, MASK_FULL)) alu_ctrl = ALU_ADD;
    else if (opc_match(opcode, OPC_CBZ, MASK_CB))    alu_ctrl = ALU_PASSB;
    else                                             legal    = 1'b0;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU initiator: request in, drive ALU, capture result, respond (option ALU_ISSUE_PIPE_EN)
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 11
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [OPW-1:0]   Opcode,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             RespValid,
  input  logic             RespReady,
  output logic [WIDTH-1:0] Result,
  output logic             ResultZero,
  output logic             IllegalOp,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusW,
  input  logic             Zero
);

  issue_state_t state_q, state_d;
  logic [3:0]   dec_ctrl;
  logic         dec_legal;
  logic         req_fire;
  logic         resp_fire;

  alu_op_decode u_decode (
    .opcode   (Opcode),
    .alu_ctrl (dec_ctrl),
    .legal    (dec_legal)
  );

  assign RespValid = (state_q == ST_RESP);
  assign req_fire  = ReqValid & ReqReady;
  assign resp_fire = RespValid & RespReady;

  // Request-side readiness and next-state selection
  always_comb begin
    ReqReady = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (req_fire) state_d = dec_legal ? ST_EXEC : ST_RESP;
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
`ifdef ALU_ISSUE_PIPE_EN
        ReqReady = RespReady;
`else
        ReqReady = 1'b0;
`endif
        if (resp_fire) begin
          if (req_fire) state_d = dec_legal ? ST_EXEC : ST_RESP;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, ALU input latches and captured response
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      BusA       <= '0;
      BusB       <= '0;
      ALUCtrl    <= ALU_AND;
      Result     <= '0;
      ResultZero <= 1'b0;
      IllegalOp  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        if (dec_legal) begin
          BusA    <= OpA;
          BusB    <= OpB;
          ALUCtrl <= dec_ctrl;
        end else begin
          // Illegal ops never reach the ALU; answer directly with a flagged zero
          Result     <= '0;
          ResultZero <= 1'b0;
          IllegalOp  <= 1'b1;
        end
      end else if (state_q == ST_EXEC) begin
        Result     <= BusW;
        ResultZero <= Zero;
        IllegalOp  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  localparam int WIDTH = 64;
  localparam int OPW   = 11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ0 = 11'b10110100000;
  localparam logic [10:0] OP_CBZ7 = 11'b10110100111;
  localparam logic [10:0] OP_BAD0 = 11'b00000000000;
  localparam logic [10:0] OP_BAD1 = 11'b10001011001;
  localparam logic [10:0] OP_BAD2 = 11'b10110101000;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             ReqValid;
  logic             ReqReady;
  logic [OPW-1:0]   Opcode;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             RespValid;
  logic             RespReady;
  logic [WIDTH-1:0] Result;
  logic             ResultZero;
  logic             IllegalOp;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] BusW;
  logic             Zero;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_issue_ctrl #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .Opcode     (Opcode),
    .OpA        (OpA),
    .OpB        (OpB),
    .RespValid  (RespValid),
    .RespReady  (RespReady),
    .Result     (Result),
    .ResultZero (ResultZero),
    .IllegalOp  (IllegalOp),
    .BusA       (BusA),
    .BusB       (BusB),
    .ALUCtrl    (ALUCtrl),
    .BusW       (BusW),
    .Zero       (Zero)
  );

  // Behavioural single-cycle ALU
  always_comb begin
    BusW = '0;
    case (ALUCtrl)
      4'b0000: BusW = BusA & BusB;
      4'b0001: BusW = BusA | BusB;
      4'b0010: BusW = BusA + BusB;
      4'b0110: BusW = BusA - BusB;
      4'b0111: BusW = BusB;
      default: BusW = '0;
    endcase
    Zero = (BusB == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic legal_op(input string tag, input logic [10:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] ctrl,
                          input logic [63:0] res, input logic zero);
    Opcode = op; OpA = a; OpB = b; ReqValid = 1'b1; RespReady = 1'b1;
    check({tag, "_reqready"}, 64'(ReqReady), 64'd1);
    step();
    ReqValid = 1'b0; Opcode = '0; OpA = '0; OpB = '0;
    check({tag, "_exec_ctrl"}, 64'(ALUCtrl), 64'(ctrl));
    check({tag, "_exec_busa"}, BusA, a);
    check({tag, "_exec_respvalid"}, 64'(RespValid), 64'd0);
    check({tag, "_exec_reqready"}, 64'(ReqReady), 64'd0);
    step();
    check({tag, "_respvalid"}, 64'(RespValid), 64'd1);
    check({tag, "_result"}, Result, res);
    check({tag, "_zero"}, 64'(ResultZero), 64'(zero));
    check({tag, "_illegal"}, 64'(IllegalOp), 64'd0);
    step();
    check({tag, "_idle_respvalid"}, 64'(RespValid), 64'd0);
    check({tag, "_idle_reqready"}, 64'(ReqReady), 64'd1);
  endtask

  task automatic illegal_op(input string tag, input logic [10:0] op, input logic [3:0] prev_ctrl);
    Opcode = op; OpA = 64'h1234; OpB = 64'h5678; ReqValid = 1'b1; RespReady = 1'b1;
    step();
    ReqValid = 1'b0;
    check({tag, "_respvalid"}, 64'(RespValid), 64'd1);
    check({tag, "_illegal"}, 64'(IllegalOp), 64'd1);
    check({tag, "_result"}, Result, 64'd0);
    check({tag, "_zero"}, 64'(ResultZero), 64'd0);
    check({tag, "_ctrl_kept"}, 64'(ALUCtrl), 64'(prev_ctrl));
    step();
    check({tag, "_idle_reqready"}, 64'(ReqReady), 64'd1);
    check({tag, "_idle_respvalid"}, 64'(RespValid), 64'd0);
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; RespReady = 1'b0;
    Opcode = '0; OpA = '0; OpB = '0;
    step();
    step();
    Reset = 1'b0;
    check("rst_busa", BusA, 64'd0);
    check("rst_busb", BusB, 64'd0);
    check("rst_ctrl", 64'(ALUCtrl), 64'd0);
    check("rst_result", Result, 64'd0);
    check("rst_zero", 64'(ResultZero), 64'd0);
    check("rst_illegal", 64'(IllegalOp), 64'd0);
    check("rst_respvalid", 64'(RespValid), 64'd0);
    check("rst_reqready", 64'(ReqReady), 64'd1);

    legal_op("add", OP_ADD, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0);
    legal_op("sub_wrap", OP_SUB, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    legal_op("and", OP_AND, 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 1'b0);
    legal_op("addi", OP_ADDI, 64'd100, 64'd23, 4'b0010, 64'd123, 1'b0);
    legal_op("subi", OP_SUBI, 64'd50, 64'd8, 4'b0110, 64'd42, 1'b0);
    legal_op("ldur", OP_LDUR, 64'h1000, 64'h8, 4'b0010, 64'h1008, 1'b0);
    legal_op("stur", OP_STUR, 64'h2000, 64'h10, 4'b0010, 64'h2010, 1'b0);
    legal_op("cbz_nz", OP_CBZ7, 64'd1, 64'h55, 4'b0111, 64'h55, 1'b0);
    legal_op("cbz", OP_CBZ0, 64'd9, 64'd0, 4'b0111, 64'd0, 1'b1);

    illegal_op("ill_zero", OP_BAD0, 4'b0111);
    illegal_op("ill_add_lsb", OP_BAD1, 4'b0111);
    illegal_op("ill_cbz_near", OP_BAD2, 4'b0111);

    // ORR under response backpressure, with a competing request held
    Opcode = OP_ORR; OpA = 64'hF0; OpB = 64'h0F; ReqValid = 1'b1; RespReady = 1'b0;
    step();
    Opcode = OP_ADD; OpA = 64'd1; OpB = 64'd1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("bp_respvalid", 64'(RespValid), 64'd1);
      check("bp_result", Result, 64'hFF);
      check("bp_reqready", 64'(ReqReady), 64'd0);
      check("bp_busa_held", BusA, 64'hF0);
      step();
    end
    ReqValid = 1'b0; RespReady = 1'b1;
    step();
    check("bp_release_idle", 64'(RespValid), 64'd0);
    check("bp_release_ready", 64'(ReqReady), 64'd1);
    check("bp_ctrl_last", 64'(ALUCtrl), 64'b0001);

    // Reset while in EXEC discards the operation
    Opcode = OP_ADD; OpA = 64'd3; OpB = 64'd4; ReqValid = 1'b1; RespReady = 1'b1;
    step();
    ReqValid = 1'b0; Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rst_exec_respvalid", 64'(RespValid), 64'd0);
    check("rst_exec_reqready", 64'(ReqReady), 64'd1);
    check("rst_exec_busa", BusA, 64'd0);
    step();
    check("rst_exec_no_resp", 64'(RespValid), 64'd0);

`ifdef ALU_ISSUE_PIPE_EN
    // Back-to-back: second request accepted as first response retires
    Opcode = OP_AND; OpA = 64'hF0F0; OpB = 64'hFF00; ReqValid = 1'b1; RespReady = 1'b1;
    step();
    ReqValid = 1'b0;
    step();
    check("pipe_resp1", 64'(RespValid), 64'd1);
    check("pipe_result1", Result, 64'hF000);
    Opcode = OP_ADD; OpA = 64'd3; OpB = 64'd4; ReqValid = 1'b1;
    check("pipe_reqready_in_resp", 64'(ReqReady), 64'd1);
    step();
    ReqValid = 1'b0;
    check("pipe_exec2_respvalid", 64'(RespValid), 64'd0);
    check("pipe_exec2_ctrl", 64'(ALUCtrl), 64'b0010);
    check("pipe_exec2_busa", BusA, 64'd3);
    step();
    check("pipe_resp2", 64'(RespValid), 64'd1);
    check("pipe_result2", Result, 64'd7);
    step();
    check("pipe_idle", 64'(RespValid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU interface. Accepts a decoded-instruction request (LEGv8 opcode plus two 64-bit operands) over a valid/ready handshake.
- Drives BusA, BusB and ALUCtrl into the combinational ALU, captures BusW and Zero one cycle later, and returns them over a valid/ready response channel.
- Sits between the instruction-issue stage and the ALU in the multi-cycle datapath variant.

Parameters:
- WIDTH, 64, datapath width of operands, ALU buses and result.
- OPW, 11, opcode field width (LEGv8 bits [31:21]).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- Opcode  in  OPW  instruction opcode field.
- OpA  in  WIDTH  first operand (Rn value).
- OpB  in  WIDTH  second operand (Rm / immediate / Rt value).
- RespValid  out  1  response present.
- RespReady  in  1  consumer accepts response.
- Result  out  WIDTH  captured ALU BusW.
- ResultZero  out  1  captured ALU Zero.
- IllegalOp  out  1  opcode not decodable; valid with RespValid.
- BusA  out  WIDTH  to ALU BusA.
- BusB  out  WIDTH  to ALU BusB.
- ALUCtrl  out  4  to ALU ALUCtrl.
- BusW  in  WIDTH  from ALU result.
- Zero  in  1  from ALU. The ALU flags BusB==0; this flag is used for CBZ.

Behaviour:
- Reset (synchronous, Reset=1 at edge): state=IDLE. BusA=0, BusB=0, ALUCtrl=4'b0000, Result=0, ResultZero=0, IllegalOp=0, RespValid=0. Reset mid-operation discards any in-flight request or response with no response emitted.
- Decode (x = don't care; all other opcodes are illegal):
  - ADD 10001011000 -> 0010
  - SUB 11001011000 -> 0110
  - AND 10001010000 -> 0000
  - ORR 10101010000 -> 0001
  - ADDI 1001000100x -> 0010
  - SUBI 1101000100x -> 0110
  - LDUR 11111000010 -> 0010
  - STUR 11111000000 -> 0010
  - CBZ 10110100xxx -> 0111 (PassB)
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - ReqReady=1, RespValid=0.
  - On ReqValid&ReqReady, latch OpA->BusA, OpB->BusB and decoded code->ALUCtrl.
  - Legal opcode: go to EXEC. Illegal opcode: BusA/BusB/ALUCtrl unchanged, Result=0, ResultZero=0, IllegalOp=1, go to RESP.
- EXEC:
  - ReqReady=0. ALU inputs held stable for the whole cycle.
  - At the edge, Result<=BusW, ResultZero<=Zero, IllegalOp<=0, go to RESP.
- RESP:
  - RespValid=1. Result, ResultZero and IllegalOp held stable until RespValid&RespReady, then go to IDLE.
  - ReqReady=0 (unless the optional feature is enabled).
  - BusA, BusB and ALUCtrl keep their last values.
- Latency:
  - Legal request accepted at edge N -> RespValid=1 in the cycle after edge N+1.
  - Illegal request -> RespValid=1 in the cycle after edge N.
  - Throughput without the optional feature: one op per 3 cycles (legal), one per 2 cycles (illegal).
- Arithmetic: none local. Result is whatever BusW reports, width WIDTH. Wrap-around on ADD/SUB is the ALU's modulo 2^WIDTH behaviour.
- Backpressure: RespValid, once asserted, never drops without a handshake. Response data never changes while RespValid=1 and RespReady=0.
- ReqValid while ReqReady=0 is ignored. The requester must hold its request.

Optional Feature:
- Macro: ALU_ISSUE_PIPE_EN.
- Defined: in RESP, ReqReady=RespReady. A simultaneous response handshake and request handshake retires the current response and latches the new request in the same cycle. Next state is EXEC (legal) or RESP with IllegalOp=1 (illegal). Sustained throughput: one legal op per 2 cycles.
- Undefined: ReqReady=0 in RESP, as above.

Decomposition:
- Package alu_issue_pkg holds:
  - ALUCtrl constants: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111.
  - Opcode match patterns and masks.
  - FSM state enum.
- One sub-module, alu_op_decode: combinational, Opcode in -> ALUCtrl code plus legal flag out. alu_issue_ctrl instantiates it; it is reusable by the single-cycle control unit.

Test Plan:
- Reset with Reset=1 for 2 cycles -> all outputs 0, ReqReady=1, RespValid=0.
- ADD, OpA=5, OpB=7 (connected to ALU model), RespReady=1 -> ALUCtrl=0010 during EXEC, RespValid 2 cycles after accept, Result=12, IllegalOp=0, then ReqReady=1.
- SUB, OpA=0, OpB=1 -> Result=64'hFFFF_FFFF_FFFF_FFFF (wrap-around). CBZ, OpB=0 -> ALUCtrl=0111, Result=0, ResultZero=1.
- Opcode 11'b00000000000 -> RespValid 1 cycle after accept, IllegalOp=1, Result=0, ALUCtrl unchanged from previous op.
- ORR, OpA=F0, OpB=0F, RespReady=0 for 4 cycles -> RespValid stays 1, Result=FF stable, ReqReady=0. A new ReqValid meanwhile is not accepted.
- With ALU_ISSUE_PIPE_EN: back-to-back AND/ADD requests with RespReady=1 -> second accepted in the same cycle the first response retires. Response spacing is 2 cycles. Assert Reset during EXEC -> no response emitted, IDLE next cycle.
